imem_sync_loadable: RTL and testbench
=====================================

// Module: imem_sync_loadable
// PURPOSE
//  Parametrised, clocked instruction memory that replaces the fixed combinational ROM.
//  Fetch is registered: address in, instruction out one cycle later, with a valid flag
//  and an out-of-range flag. A serial load port rewrites the program at run time.
//  Sits between the PC register and the decoder of the lab single-cycle/multi-cycle CPU.
// PARAMETERS
//  DATA_W   8      instruction width in bits
//  ADDR_W   8      fetch address width in bits
//  DEPTH    16     number of words stored; must satisfy 5 <= DEPTH <= 2**ADDR_W
//  NOP_WORD 8'h00  word returned for out-of-range fetches and stored in unused entries
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high reset
//  fetch_req   in   1       fetch request this cycle
//  fetch_addr  in   ADDR_W  word address to fetch
//  instr       out  DATA_W  fetched instruction (registered)
//  instr_valid out  1       instr holds the result of last cycle's accepted fetch
//  addr_err    out  1       last accepted fetch had fetch_addr >= DEPTH
//  fetch_stall out  1       high in LOAD; fetch_req is ignored while high
//  load_start  in   1       pulse: begin (or restart) a program load at word 0
//  load_valid  in   1       load_data is valid this cycle
//  load_data   in   DATA_W  next program word
//  load_last   in   1       qualifies load_valid: this is the final word
//  load_ready  out  1       memory accepts a load word this cycle (high in LOAD)
//  load_ovf    out  1       sticky: a load word arrived with write pointer >= DEPTH
//  load_count  out  ADDR_W+1 words written by the current/last load
// BEHAVIOUR
//  Reset (async): state=RUN; mem[0..4]=8'h49,8'hC1,8'h18,8'hA9,8'h4D, mem[5..DEPTH-1]=NOP_WORD;
//   instr=NOP_WORD, instr_valid=0, addr_err=0, fetch_stall=0, load_ready=0, load_ovf=0,
//   load_count=0, write pointer wp=0. Reset mid-load discards the partial program.
//  FSM states RUN, LOAD.
//   RUN: load_start -> LOAD next cycle, wp<=0, load_count<=0, load_ovf<=0.
//   LOAD: load_ready=1, fetch_stall=1. load_valid: if wp<DEPTH write mem[wp]<=load_data,
//     wp++, load_count++; else drop word, set load_ovf. load_valid&load_last -> RUN.
//   LOAD: load_start restarts: wp<=0, load_count<=0, load_ovf<=0; any load_valid that
//     same cycle is dropped.
//  Fetch (RUN only): fetch_req at edge N -> at edge N+1 instr_valid=1,
//   instr = (fetch_addr<DEPTH) ? mem[fetch_addr] : NOP_WORD, addr_err=(fetch_addr>=DEPTH).
//   No fetch_req (or in LOAD) -> instr_valid=0, instr and addr_err hold previous value.
//  Latency: 1 cycle, throughput 1 fetch/cycle, back-to-back fetches allowed.
//  Simultaneous: fetch_req with load_start in RUN -> fetch served from pre-load contents;
//   LOAD entered next cycle. Fetch reads old contents; no write/read bypass needed.
//  Widths: fetch_addr compared unsigned against DEPTH; no wrap-around; wp saturates at
//   DEPTH (overflow words never alias low addresses); load_count saturates at DEPTH.
//  Entries not rewritten by a short load keep their previous contents.
// STRUCTURE
//  Shared package imem_pkg: state encoding (RUN=1'b0, LOAD=1'b1), boot image constants
//   BOOT_W0..BOOT_W4, default NOP_WORD.
//  One sub-module: imem_load_ctrl (FSM, wp, load_count, load_ovf, write enable).
//  Storage array and registered read port stay in the top module.
// TESTING
//  1 Reset, fetch addr 0..4 back-to-back -> instr 49,C1,18,A9,4D one cycle later, valid=1.
//  2 Fetch addr 5 -> 8'h00, addr_err=0; fetch addr 16 (DEPTH=16) -> 8'h00, addr_err=1.
//  3 load_start, load 3 words AA,BB,CC (last on CC) -> load_count=3; fetch 0..4 ->
//    AA,BB,CC,A9,4D; fetch_req during LOAD -> instr_valid=0, fetch_stall=1.
//  4 Load 18 words with DEPTH=16 -> load_ovf=1, load_count=16, mem[0] not overwritten by
//    word 17/18; next load_start clears load_ovf.
//  5 Assert reset after 2 of 4 load words -> state RUN, fetch 0 returns 8'h49.
//  6 fetch_req addr 1 and load_start same cycle -> instr=C1 valid next cycle, then LOAD.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory.
//   imem_state_e     : load controller state encoding (run / load)
//   BOOT_W0..BOOT_W4 : boot program restored into words 0..4 on reset
//   DEFAULT_NOP_WORD : default filler word for unused entries and out-of-range fetches
//   boot_word()      : maps a word index to its boot-image value
package imem_pkg;

  typedef enum logic {
    StRun  = 1'b0,
    StLoad = 1'b1
  } imem_state_e;

  localparam int unsigned BOOT_LEN = 5;

  localparam logic [7:0] BOOT_W0 = 8'h49;
  localparam logic [7:0] BOOT_W1 = 8'hC1;
  localparam logic [7:0] BOOT_W2 = 8'h18;
  localparam logic [7:0] BOOT_W3 = 8'hA9;
  localparam logic [7:0] BOOT_W4 = 8'h4D;

  localparam logic [7:0] DEFAULT_NOP_WORD = 8'h00;

  // Indices past the boot image return DEFAULT_NOP_WORD; callers substitute their own
  // NOP word for those entries.
  function automatic logic [7:0] boot_word(input int unsigned idx);
    case (idx)
      0:       return BOOT_W0;
      1:       return BOOT_W1;
      2:       return BOOT_W2;
      3:       return BOOT_W3;
      4:       return BOOT_W4;
      default: return DEFAULT_NOP_WORD;
    endcase
  endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// Load controller for the loadable instruction memory.
// Owns the run/load state, the write pointer, the sticky overflow flag and the write
// enable for the storage array.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   load_start   : begin or restart a program load at word 0
//   load_valid   : a program word is presented this cycle
//   load_last    : qualifies load_valid; final word of the program
//   loading      : high while in the load state (drives load_ready / fetch_stall)
//   we, waddr    : write strobe and word index into the storage array
//   load_ovf     : sticky, a word arrived after the array was full
//   load_count   : words written by the current/last load
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              loading,
  output logic              we,
  output logic [IDX_W-1:0]  waddr,
  output logic              load_ovf,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  imem_state_e     state_q, state_d;
  logic [ADDR_W:0] wp_q, wp_d;
  logic            ovf_q, ovf_d;
  logic            wp_full;

  // wp saturates at DEPTH, so full means exactly DEPTH; overflow never wraps to word 0.
  assign wp_full = (wp_q >= DepthW);

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    case (state_q)
      StRun: begin
        if (load_start) begin
          state_d = StLoad;
          wp_d    = '0;
          ovf_d   = 1'b0;
        end
      end
      StLoad: begin
        if (load_start) begin
          // Restart wins: any word presented in the same cycle is dropped.
          wp_d  = '0;
          ovf_d = 1'b0;
        end else if (load_valid) begin
          if (!wp_full) begin
            we   = 1'b1;
            wp_d = wp_q + (ADDR_W + 1)'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (load_last) begin
            state_d = StRun;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      wp_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      ovf_q   <= ovf_d;
    end
  end

  // Every accepted word advances the pointer and the count together, so one register
  // serves both.
  assign load_count = wp_q;
  assign waddr      = wp_q[IDX_W-1:0];
  assign load_ovf   = ovf_q;
  assign loading    = (state_q == StLoad);

endmodule

// File: rtl/imem_sync_loadable.sv
// Clocked instruction memory with a registered fetch port and a serial load port.
// Sits between the PC register and the decoder; the load port rewrites the program
// at run time while fetches are stalled.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   fetch_req    : fetch request this cycle (ignored while fetch_stall)
//   fetch_addr   : word address to fetch
//   instr        : registered instruction, NOP_WORD for out-of-range addresses
//   instr_valid  : instr holds the result of last cycle's accepted fetch
//   addr_err     : last accepted fetch addressed a word >= DEPTH
//   fetch_stall  : high while a load is in progress
//   load_start   : begin or restart a program load at word 0
//   load_valid   : load_data valid this cycle
//   load_data    : next program word
//   load_last    : qualifies load_valid; final word
//   load_ready   : memory accepts load words (load in progress)
//   load_ovf     : sticky, a word arrived after the array was full
//   load_count   : words written by the current/last load
module imem_sync_loadable
  import imem_pkg::*;
#(
  parameter int unsigned          DATA_W   = 8,
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          DEPTH    = 16,
  parameter logic [DATA_W-1:0]    NOP_WORD = DATA_W'(DEFAULT_NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_err,
  output logic              fetch_stall,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_ovf,
  output logic [ADDR_W:0]   load_count
);

  localparam int unsigned     IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  logic              loading;
  logic              we;
  logic [IDX_W-1:0]  waddr;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              fetch_go;
  logic              in_range;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              addr_err_q, addr_err_d;

  imem_load_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_load_ctrl (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_last  (load_last),
    .loading    (loading),
    .we         (we),
    .waddr      (waddr),
    .load_ovf   (load_ovf),
    .load_count (load_count)
  );

  // Storage: reset restores the boot program so a reset mid-load discards the partial
  // image. Words not rewritten by a short load keep their contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[IDX_W'(i)] <= (i < BOOT_LEN) ? DATA_W'(boot_word(i)) : NOP_WORD;
      end
    end else if (we) begin
      mem_q[waddr] <= load_data;
    end
  end

  // Fetches are accepted only outside a load. A fetch in the same cycle as load_start is
  // still accepted and reads the pre-load contents.
  assign fetch_go = fetch_req && !loading;
  assign in_range = ({1'b0, fetch_addr} < DepthW);

  always_comb begin
    instr_d       = instr_q;
    addr_err_d    = addr_err_q;
    instr_valid_d = 1'b0;
    if (fetch_go) begin
      instr_valid_d = 1'b1;
      addr_err_d    = !in_range;
      instr_d       = in_range ? mem_q[fetch_addr[IDX_W-1:0]] : NOP_WORD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign addr_err    = addr_err_q;
  assign fetch_stall = loading;
  assign load_ready  = loading;

endmodule

// File: tb/tb_imem_sync_loadable.sv
module tb_imem_sync_loadable;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fetch_req = 1'b0;
  logic [7:0] fetch_addr = '0;
  logic [7:0] instr;
  logic       instr_valid;
  logic       addr_err;
  logic       fetch_stall;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       load_ovf;
  logic [8:0] load_count;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [7:0] instr;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  imem_sync_loadable #(
    .DATA_W   (8),
    .ADDR_W   (8),
    .DEPTH    (16),
    .NOP_WORD (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .addr_err    (addr_err),
    .fetch_stall (fetch_stall),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_ovf    (load_ovf),
    .load_count  (load_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Monitor: every presented instruction is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got instr %0h with no fetch outstanding", instr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("fetch_instr", {24'h0, instr}, {24'h0, e.instr});
          chk("fetch_addr_err", {31'h0, addr_err}, {31'h0, e.err});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [7:0] a, input logic [7:0] want, input logic err);
    exp_t e;
    fetch_req  = 1'b1;
    fetch_addr = a;
    e.instr    = want;
    e.err      = err;
    exp_q.push_back(e);
    cyc();
    fetch_req = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    cyc();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  logic [7:0] boot [5];

  initial begin
    boot[0] = 8'h49; boot[1] = 8'hC1; boot[2] = 8'h18; boot[3] = 8'hA9; boot[4] = 8'h4D;

    // Reset state
    #12;
    chk("rst_instr", {24'h0, instr}, 32'h00);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
    chk("rst_stall", {31'h0, fetch_stall}, 32'h0);
    chk("rst_load_ready", {31'h0, load_ready}, 32'h0);
    chk("rst_ovf", {31'h0, load_ovf}, 32'h0);
    chk("rst_count", {23'h0, load_count}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Boot image, back-to-back
    for (int i = 0; i < 5; i++) fetch(8'(i), boot[i], 1'b0);
    // Range boundaries
    fetch(8'd5, 8'h00, 1'b0);
    fetch(8'd15, 8'h00, 1'b0);
    fetch(8'd16, 8'h00, 1'b1);
    fetch(8'd255, 8'h00, 1'b1);
    fetch(8'd2, 8'h18, 1'b0);

    // Short load; fetch during load must be ignored
    start_load();
    chk("load_stall", {31'h0, fetch_stall}, 32'h1);
    chk("load_ready", {31'h0, load_ready}, 32'h1);
    fetch_req  = 1'b1;
    fetch_addr = 8'd0;
    cyc();
    fetch_req = 1'b0;
    chk("stalled_valid", {31'h0, instr_valid}, 32'h0);
    load_word(8'hAA, 1'b0);
    load_word(8'hBB, 1'b0);
    load_word(8'hCC, 1'b1);
    chk("short_count", {23'h0, load_count}, 32'd3);
    chk("short_stall", {31'h0, fetch_stall}, 32'h0);
    chk("short_ovf", {31'h0, load_ovf}, 32'h0);
    fetch(8'd0, 8'hAA, 1'b0);
    fetch(8'd1, 8'hBB, 1'b0);
    fetch(8'd2, 8'hCC, 1'b0);
    fetch(8'd3, 8'hA9, 1'b0);
    fetch(8'd4, 8'h4D, 1'b0);

    // Overflow: 18 words into 16 entries
    start_load();
    for (int i = 0; i < 18; i++) load_word(8'(8'h10 + i), (i == 17));
    chk("ovf_flag", {31'h0, load_ovf}, 32'h1);
    chk("ovf_count", {23'h0, load_count}, 32'd16);
    fetch(8'd0, 8'h10, 1'b0);
    fetch(8'd15, 8'h1F, 1'b0);
    start_load();
    chk("ovf_cleared", {31'h0, load_ovf}, 32'h0);
    chk("count_cleared", {23'h0, load_count}, 32'd0);
    load_word(8'h77, 1'b1);
    chk("one_count", {23'h0, load_count}, 32'd1);
    fetch(8'd0, 8'h77, 1'b0);
    fetch(8'd1, 8'h11, 1'b0);

    // Restart mid-load; word presented with load_start is dropped
    start_load();
    load_word(8'h55, 1'b0);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h66;
    load_last  = 1'b1;
    cyc();
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("restart_count", {23'h0, load_count}, 32'd0);
    chk("restart_stall", {31'h0, fetch_stall}, 32'h1);
    load_word(8'h99, 1'b1);
    fetch(8'd0, 8'h99, 1'b0);
    fetch(8'd1, 8'h11, 1'b0);

    // Async reset in the middle of a load
    start_load();
    load_word(8'hA1, 1'b0);
    load_word(8'hA2, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_stall", {31'h0, fetch_stall}, 32'h0);
    chk("midrst_count", {23'h0, load_count}, 32'd0);
    #1 reset = 1'b0;
    cyc();
    fetch(8'd0, 8'h49, 1'b0);
    fetch(8'd1, 8'hC1, 1'b0);
    fetch(8'd5, 8'h00, 1'b0);

    // Fetch coinciding with load_start uses pre-load contents
    fetch_req  = 1'b1;
    fetch_addr = 8'd1;
    load_start = 1'b1;
    begin
      exp_t e;
      e.instr = 8'hC1;
      e.err   = 1'b0;
      exp_q.push_back(e);
    end
    cyc();
    fetch_req  = 1'b0;
    load_start = 1'b0;
    chk("simul_stall", {31'h0, fetch_stall}, 32'h1);
    load_word(8'h5A, 1'b1);
    fetch(8'd0, 8'h5A, 1'b0);
    fetch(8'd1, 8'hC1, 1'b0);

    cyc();
    cyc();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1);
  end

endmodule
